// File: rtl/max_stream_collector.sv
// Collects a frame of active-low operands and reports the maximum, the position of
// its first occurrence, the operand count and an overflow flag.
module max_stream_collector #(
  parameter int DATA_W = 3,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data_n,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [IDX_W-1:0]  out_idx,
  output logic [IDX_W-1:0]  out_count,
  output logic              out_ovf
);

  // state | meaning
  // IDLE  | waiting for the first operand of a frame
  // ACCUM | accumulating the remaining operands
  // HOLD  | result presented, waiting for out_ready
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [IDX_W-1:0] POS_TOP = '1;

  state_t            state, state_nxt;
  logic              alive;
  logic              xfer;
  logic              wrap;
  logic [DATA_W-1:0] v;
  logic [DATA_W-1:0] max_q;
  logic [IDX_W-1:0]  idx_q, pos_q;
  logic              ovf_q;

  always_comb begin
    state_nxt = state;
    v         = ~in_data_n;
    in_ready  = alive && (state != HOLD);
    xfer      = in_valid && in_ready;
    out_valid = (state == HOLD);
    wrap      = (pos_q == POS_TOP);
    case (state)
      IDLE:    if (xfer) state_nxt = in_last ? HOLD : ACCUM;
      ACCUM:   if (xfer && in_last) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
    end
  end

  // The transfer that overflows the position counter must not move idx either,
  // since pos+1 is no longer representable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      idx_q <= '0;
      pos_q <= '0;
      ovf_q <= 1'b0;
    end else if (xfer) begin
      if (state == IDLE) begin
        max_q <= v;
        idx_q <= '0;
        pos_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (wrap) ovf_q <= 1'b1;
        else      pos_q <= pos_q + 1'b1;
        if (v > max_q) begin
          max_q <= v;
          if (!ovf_q && !wrap) idx_q <= pos_q + 1'b1;
        end
      end
    end
  end

  assign out_max   = max_q;
  assign out_idx   = idx_q;
  assign out_count = pos_q;
  assign out_ovf   = ovf_q;

endmodule

// File: doc/max_stream_collector.md
MAX_STREAM_COLLECTOR -- requirements
Module: max_stream_collector

Interface
REQ-001 Parameter DATA_W, default 3, SHALL set the operand width; it matches the comparator/mux slice output width.
REQ-002 Parameter IDX_W, default 4, SHALL set the width of the operand index and count; a frame holds at most 2^IDX_W operands.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL flag that an operand is present on in_data_n.
REQ-006 in_ready  output  1  SHALL signal that the collector accepts an operand this cycle.
REQ-007 in_data_n  input  DATA_W  SHALL carry the operand in active-low encoding, as driven by the slice mux outputs.
REQ-008 in_last  input  1  SHALL mark the final operand of a frame.
REQ-009 out_valid  output  1  SHALL flag that a frame result is present.
REQ-010 out_ready  input  1  SHALL signal that the downstream consumer takes the result.
REQ-011 out_max  output  DATA_W  SHALL carry the frame maximum in true (active-high) polarity.
REQ-012 out_idx  output  IDX_W  SHALL carry the zero-based frame position of the first occurrence of the maximum.
REQ-013 out_count  output  IDX_W  SHALL carry the number of operands in the frame minus one.
REQ-014 out_ovf  output  1  SHALL flag that the frame exceeded 2^IDX_W operands.

Function
REQ-015 The decoded operand SHALL be v = ~in_data_n, with an unsigned DATA_W-bit compare.
REQ-016 An operand transfer SHALL occur only in a cycle where in_valid and in_ready are both 1.
REQ-017 The state machine SHALL have three states: IDLE, ACCUM and HOLD.
REQ-018 IDLE SHALL hold in_ready=1; the first transfer loads max=v, idx=0, pos=0 and ovf=0.
REQ-019 From IDLE, that first transfer SHALL move the state to ACCUM, or to HOLD if in_last=1 (a single-operand frame).
REQ-020 ACCUM SHALL hold in_ready=1; each transfer increments pos.
REQ-021 In ACCUM, if v > max, the transfer SHALL update max=v and idx=pos+1.
REQ-022 Equal values SHALL NOT update idx, so the earliest position wins a tie.
REQ-023 A transfer with in_last=1 SHALL move the state to HOLD.
REQ-024 HOLD SHALL hold in_ready=0 and out_valid=1, with out_max, out_idx, out_count and out_ovf stable.
REQ-025 HOLD SHALL exit to IDLE on the cycle after out_valid and out_ready are both 1.
REQ-026 Result latency SHALL be one cycle: out_valid rises on the edge after the in_last transfer.
REQ-027 Position wrap: when pos = 2^IDX_W-1 and another transfer occurs, the transfer SHALL set ovf=1 sticky, saturate pos and out_count, and still compare v against max.
REQ-028 After ovf is set, idx SHALL NOT update.
REQ-029 There SHALL be no input/output overlap; in_ready=0 in HOLD, so the next frame waits for the result to be taken.
REQ-030 An in_valid pulse while in_ready=0 SHALL be ignored, and the upstream holds its data.
REQ-031 out_valid SHALL NOT drop without the out_ready handshake.

Reset
REQ-032 When rst_n=0, the block SHALL asynchronously enter IDLE and drive in_ready=0.
REQ-033 During reset, out_valid, out_max, out_idx, out_count and out_ovf SHALL all be 0.
REQ-034 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-035 A reset mid-frame or in HOLD SHALL discard the partial frame or pending result; no result is emitted for it.

Verification
REQ-036 Frame in_data_n = 3'b101, 3'b000, 3'b011, last on the third, out_ready=1 -> out_max=7, out_idx=1, out_count=2, out_ovf=0, out_valid high for 1 cycle.
REQ-037 Ties (values 4, 6, 6, 2) -> out_max=6, out_idx=1; a single-operand frame (v=0, last) -> out_max=0, out_idx=0, out_count=0.
REQ-038 out_ready held 0 for 5 cycles in HOLD -> outputs stable, in_ready=0, a pending in_valid is not accepted; out_ready=1 -> IDLE next cycle.
REQ-039 IDX_W=2 with 6 operands, max at position 5 -> out_count=3, out_ovf=1, out_max correct, out_idx frozen at the pre-overflow value.
REQ-040 rst_n pulsed low mid-frame after 2 operands -> out_valid never rises for that frame; the next frame (values 1, 2, last) -> out_max=2, out_idx=1.
REQ-041 Random valid/ready back-pressure over 1000 frames -> results match a reference model, with no lost or duplicated operands.
